// File: rtl/leve_pkg.sv
// Shared types for the leve integer execute stage.
package leve_pkg;

  // Codebase-wide integer datapath width.
  localparam int unsigned XlenDefault = 64;

  typedef enum logic [3:0] {
    OpAdd   = 4'd0,
    OpSub   = 4'd1,
    OpSll   = 4'd2,
    OpSlt   = 4'd3,
    OpSltu  = 4'd4,
    OpXor   = 4'd5,
    OpSrl   = 4'd6,
    OpSra   = 4'd7,
    OpOr    = 4'd8,
    OpAnd   = 4'd9,
    OpMul   = 4'd10,
    OpMulhu = 4'd11
  } alu_op_t;

  typedef enum logic [0:0] {
    StIdle = 1'b0,
    StMul  = 1'b1
  } exu_state_t;

endpackage

// File: rtl/leve_mul_seq.sv
// Iterative shift-add unsigned multiplier: one partial product per cycle, XLEN cycles.
module leve_mul_seq
  import leve_pkg::*;
#(
  parameter int unsigned XLEN = XlenDefault
) (
  input  logic            CLK,
  input  logic            RSTn,
  input  logic            start_i,
  input  logic [XLEN-1:0] a_i,
  input  logic [XLEN-1:0] b_i,
  input  logic            hi_sel_i,
  output logic            busy_o,
  output logic            done_o,
  output logic [XLEN-1:0] result_o
);

  localparam int unsigned SHW = $clog2(XLEN);

  exu_state_t        state_q, state_d;
  logic [SHW-1:0]    cnt_q, cnt_d;
  logic [XLEN-1:0]   a_q, a_d, b_q, b_d;
  logic [2*XLEN-1:0] acc_q, acc_d;
  logic              hi_q, hi_d;

  logic [2*XLEN-1:0] partial;
  logic [2*XLEN-1:0] acc_sum;
  logic              last_iter;

  // Accumulate this iteration's partial product; acc_sum is the product after the step.
  always_comb begin
    partial   = b_q[cnt_q] ? ({{XLEN{1'b0}}, a_q} << cnt_q) : '0;
    acc_sum   = acc_q + partial;
    last_iter = (cnt_q == SHW'(XLEN - 1));
  end

  // Next-state: latch operands on start, iterate while in StMul.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    a_d     = a_q;
    b_d     = b_q;
    acc_d   = acc_q;
    hi_d    = hi_q;
    unique case (state_q)
      StIdle: begin
        if (start_i) begin
          state_d = StMul;
          a_d     = a_i;
          b_d     = b_i;
          acc_d   = '0;
          cnt_d   = '0;
          hi_d    = hi_sel_i;
        end
      end
      StMul: begin
        acc_d = acc_sum;
        cnt_d = cnt_q + 1'b1;
        if (last_iter) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // State register.
  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      acc_q   <= '0;
      hi_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      a_q     <= a_d;
      b_q     <= b_d;
      acc_q   <= acc_d;
      hi_q    <= hi_d;
    end
  end

  // Result is taken from the final sum so the top can register it on the done cycle.
  assign busy_o   = (state_q == StMul);
  assign done_o   = busy_o && last_iter;
  assign result_o = hi_q ? acc_sum[2*XLEN-1:XLEN] : acc_sum[XLEN-1:0];

endmodule

// File: rtl/leve_exu.sv
// Integer execute stage: single-cycle ALU plus iterative MUL/MULHU, drives RF write port.
module leve_exu
  import leve_pkg::*;
#(
  parameter int unsigned XLEN = XlenDefault
) (
  input  logic            CLK,
  input  logic            RSTn,
  input  logic            RS_D_VALID,
  input  logic [XLEN-1:0] RS1_D,
  input  logic [XLEN-1:0] RS2_D,
  input  logic [3:0]      ALU_OP,
  input  logic [4:0]      RD_IN,
  output logic            BUSY,
  output logic            RD_WE,
  output logic [4:0]      RD,
  output logic [XLEN-1:0] ALU_OUT
);

  localparam int unsigned SHW = $clog2(XLEN);

  alu_op_t         op;
  logic [SHW-1:0]  shamt;
  logic            accept, is_mul, mul_start;
  logic            mul_busy, mul_done;
  logic [XLEN-1:0] mul_result;
  logic [XLEN-1:0] alu_res;
  logic            alu_ok;

  logic            rd_we_q, rd_we_d;
  logic [4:0]      rd_q, rd_d;
  logic [4:0]      rd_mul_q, rd_mul_d;
  logic [XLEN-1:0] out_q, out_d;

  assign op        = alu_op_t'(ALU_OP);
  assign shamt     = RS2_D[SHW-1:0];
  assign accept    = RS_D_VALID && !mul_busy;
  assign is_mul    = (op == OpMul) || (op == OpMulhu);
  assign mul_start = accept && is_mul;

  leve_mul_seq #(
    .XLEN (XLEN)
  ) u_mul (
    .CLK      (CLK),
    .RSTn     (RSTn),
    .start_i  (mul_start),
    .a_i      (RS1_D),
    .b_i      (RS2_D),
    .hi_sel_i (op == OpMulhu),
    .busy_o   (mul_busy),
    .done_o   (mul_done),
    .result_o (mul_result)
  );

  // Single-cycle ALU; alu_ok flags codes that produce a write-back.
  always_comb begin
    alu_res = '0;
    alu_ok  = 1'b1;
    case (op)
      OpAdd:   alu_res = RS1_D + RS2_D;
      OpSub:   alu_res = RS1_D - RS2_D;
      OpSll:   alu_res = RS1_D << shamt;
      OpSrl:   alu_res = RS1_D >> shamt;
      OpSra:   alu_res = $unsigned($signed(RS1_D) >>> shamt);
      OpSlt:   alu_res = {{(XLEN-1){1'b0}}, $signed(RS1_D) < $signed(RS2_D)};
      OpSltu:  alu_res = {{(XLEN-1){1'b0}}, RS1_D < RS2_D};
      OpXor:   alu_res = RS1_D ^ RS2_D;
      OpOr:    alu_res = RS1_D | RS2_D;
      OpAnd:   alu_res = RS1_D & RS2_D;
      default: alu_ok  = 1'b0;
    endcase
  end

  // Write-back selection; mul_done and accept are exclusive since accept needs !mul_busy.
  always_comb begin
    rd_we_d  = 1'b0;
    rd_d     = rd_q;
    out_d    = out_q;
    rd_mul_d = rd_mul_q;
    if (mul_done) begin
      rd_d    = rd_mul_q;
      out_d   = mul_result;
      rd_we_d = (rd_mul_q != 5'd0);
    end else if (mul_start) begin
      rd_mul_d = RD_IN;
    end else if (accept && alu_ok) begin
      rd_d    = RD_IN;
      out_d   = alu_res;
      rd_we_d = (RD_IN != 5'd0);
    end
  end

  // Write-back registers.
  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      rd_we_q  <= 1'b0;
      rd_q     <= '0;
      rd_mul_q <= '0;
      out_q    <= '0;
    end else begin
      rd_we_q  <= rd_we_d;
      rd_q     <= rd_d;
      rd_mul_q <= rd_mul_d;
      out_q    <= out_d;
    end
  end

  assign BUSY    = mul_busy;
  assign RD_WE   = rd_we_q;
  assign RD      = rd_q;
  assign ALU_OUT = out_q;

endmodule

// File: doc/leve_exu.md
Name: leve_exu

Overview:
- Integer execute stage directly downstream of the integer register file.
- Consumes the registered operand pair and valid strobe, plus the opcode and destination register that the decoder delays to align with them.
- Computes single-cycle ALU results, and MUL/MULHU with an iterative shift-add multiplier.
- Drives the register-file write port (RD_WE, RD, ALU_OUT) and a BUSY stall back to the decoder.

Parameters:
- XLEN, 64, datapath width; equals the codebase-wide XLEN define.
- SHW, $clog2(XLEN), shift-amount width (derived, not overridable).

Ports:
- CLK  in  1  clock; all state on posedge.
- RSTn  in  1  asynchronous active-low reset.
- RS_D_VALID  in  1  operands valid, from the register file.
- RS1_D  in  XLEN  operand A.
- RS2_D  in  XLEN  operand B (register or immediate, already selected by the register file).
- ALU_OP  in  4  operation code (alu_op_t), aligned with RS_D_VALID.
- RD_IN  in  5  destination register, aligned with RS_D_VALID.
- BUSY  out  1  multiplier occupied; upstream must hold.
- RD_WE  out  1  write-back strobe, one cycle per result.
- RD  out  5  write-back register index.
- ALU_OUT  out  XLEN  write-back data.

Behaviour:
- Reset (asynchronous, any state including mid-multiply):
  - State goes to IDLE; counter and product register cleared.
  - RD_WE=0, RD=0, ALU_OUT=0; BUSY=0.
- Accept: an operation is accepted on a posedge where RS_D_VALID=1 and state=IDLE.
  - While BUSY=1, RS_D_VALID is ignored. Upstream holds RS_D_VALID, operands, ALU_OP and RD_IN stable until BUSY=0.
- Single-cycle ops (registered result, latency 1): RD_WE=1 and ALU_OUT valid in the cycle after accept. Op list:
  - ADD, SUB: modulo 2^XLEN.
  - SLL, SRL, SRA: shift amount is RS2_D[SHW-1:0].
  - SLT (signed), SLTU (unsigned): result zero-extended 0/1.
  - XOR, OR, AND.
- Multiply states: IDLE, MUL.
  - IDLE -> MUL on accepting MUL or MULHU. Latch A and B, clear the 2*XLEN accumulator, cnt=0, latch op and RD.
  - In MUL, one iteration per cycle: if B[cnt]==1, acc += A<<cnt (unsigned); cnt increments.
  - On the iteration where cnt==XLEN-1: state -> IDLE, RD_WE=1, ALU_OUT = product[XLEN-1:0] for MUL or product[2XLEN-1:XLEN] for MULHU.
  - BUSY = (state==MUL), combinational from state. It is high for exactly XLEN cycles after accept and low in the cycle RD_WE pulses, so back-to-back issue is legal.
- RD_WE rules:
  - Pulses exactly one cycle per accepted op; otherwise 0.
  - Forced 0 when RD==0; ALU_OUT is still updated.
- RD and ALU_OUT hold their last values when RD_WE=0.
- Undefined ALU_OP codes: accepted as a single-cycle op with RD_WE=0 and ALU_OUT unchanged.
- No operand forwarding inside the block; the hazard unit upstream handles it.

Decomposition:
- Package leve_pkg: alu_op_t enum, 4-bit:
  - ADD=0, SUB=1, SLL=2, SLT=3, SLTU=4, XOR=5, SRL=6, SRA=7, OR=8, AND=9, MUL=10, MULHU=11.
  - Also exu_state_t {IDLE, MUL}.
- One sub-module: leve_mul_seq, the iterative multiplier. Interface: start, a, b, hi_sel, busy, done, result.
- The combinational ALU stays inline.

Test Plan:
- Reset mid-multiply: assert RSTn=0 five cycles into a MUL -> BUSY=0, RD_WE=0, ALU_OUT=0 immediately. After release, a new ADD completes normally.
- ADD/SUB wrap: RS1_D=0xFFFF_FFFF_FFFF_FFFF, RS2_D=1, ADD, RD_IN=5 -> next cycle RD_WE=1, RD=5, ALU_OUT=0. Then SUB 0-1 -> ALU_OUT=0xFFFF_FFFF_FFFF_FFFF.
- Shifts and compares:
  - SRA 0x8000_0000_0000_0000 by RS2_D=0x41 (amount 1) -> 0xC000_0000_0000_0000.
  - SLT -1 vs 1 -> 1; SLTU -1 vs 1 -> 0.
- MUL timing: MUL 3*5, RD_IN=7, RS_D_VALID held high for a following ADD 1+1 (RD_IN=8) -> BUSY high for exactly 64 cycles. RD_WE with ALU_OUT=15, RD=7 in cycle 65. ADD accepted that cycle; ALU_OUT=2, RD=8 in cycle 66.
- MULHU: 0xFFFF_FFFF_FFFF_FFFF * 0xFFFF_FFFF_FFFF_FFFF -> ALU_OUT=0xFFFF_FFFF_FFFF_FFFE. The same operands with MUL -> 0x0000_0000_0000_0001.
- RD=0: ADD with RD_IN=0 -> RD_WE stays 0 and ALU_OUT updates. A following op with RD_IN=3 pulses RD_WE once.
